// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bit counter width and bus event flags.
package i2c_pkg;

    localparam int unsigned BitCntW = 3;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StAddr     = 4'd1,
        StAddrAck  = 4'd2,
        StReg      = 4'd3,
        StRegAck   = 4'd4,
        StWdata    = 4'd5,
        StWdataAck = 4'd6,
        StRdata    = 4'd7,
        StRdataAck = 4'd8,
        StIgnore   = 4'd9
    } state_e;

    typedef struct packed {
        logic start;
        logic stop;
        logic scl_rise;
        logic scl_fall;
    } bus_ev_t;

    // START/STOP are SDA transitions while SCL is high.
    function automatic bus_ev_t decode_ev(input logic scl_lvl, input logic scl_rise,
                                          input logic scl_fall, input logic sda_rise,
                                          input logic sda_fall);
        bus_ev_t ev;
        ev.start    = sda_fall & scl_lvl;
        ev.stop     = sda_rise & scl_lvl;
        ev.scl_rise = scl_rise;
        ev.scl_fall = scl_fall;
        return ev;
    endfunction

endpackage

// File: rtl/i2c_slave_target_if.sv
// Bus/application signal bundle for the I2C target.
interface i2c_slave_target_if;

    logic       scl;
    logic       sda;
    logic       sda_oe;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    modport slave (
        input  scl, sda, rd_data,
        output sda_oe, wr_strobe, wr_addr, wr_data, rd_addr, busy
    );

    modport master (
        output scl, sda, rd_data,
        input  sda_oe, wr_strobe, wr_addr, wr_data, rd_addr, busy
    );

endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser plus history flop for one open-drain line, with edge flags.
module i2c_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, hist_q;

    // Flops reset to 1 so an idle bus produces no edges after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            hist_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~hist_q;
    assign fall_o  = ~sync_q & hist_q;

endmodule

// File: rtl/i2c_slave_target.sv
// I2C target: address match, register pointer, byte writes and reads via strobe interface.
module i2c_slave_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h5A
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    i2c_slave_target_if.slave    bus
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync u_scl_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .line_i (bus.scl),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .line_i (bus.sda),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    bus_ev_t ev;
    assign ev = decode_ev(scl_lvl, scl_rise, scl_fall, sda_rise, sda_fall);

    state_e               state_q, state_d;
    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           ptr_q, ptr_d;
    logic [7:0]           wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic                 rw_q, rw_d;
    logic                 ack_ph_q, ack_ph_d;   // 0: waiting for first fall, 1: ACK/load pending
    logic                 sda_oe_q, sda_oe_d;
    logic                 wr_strobe_q, wr_strobe_d;
    logic                 busy_q, busy_d;
    logic [7:0]           shift_in;

    assign shift_in = {shift_q[6:0], sda_lvl};

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rw_q        <= 1'b0;
            ack_ph_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rw_q        <= rw_d;
            ack_ph_q    <= ack_ph_d;
            sda_oe_q    <= sda_oe_d;
            wr_strobe_q <= wr_strobe_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; START/STOP override any bit processing.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rw_d        = rw_q;
        ack_ph_d    = ack_ph_q;
        sda_oe_d    = sda_oe_q;
        wr_strobe_d = 1'b0;
        busy_d      = busy_q;

        if (ev.stop) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (ev.start) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else begin
            unique case (state_q)
                StAddr, StReg, StWdata: begin
                    if (ev.scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == '1) begin
                            ack_ph_d = 1'b0;
                            if (state_q == StAddr) begin
                                rw_d    = shift_in[0];
                                state_d = (shift_in[7:1] == SLAVE_ADDR) ? StAddrAck : StIgnore;
                            end else if (state_q == StReg) begin
                                ptr_d   = shift_in;
                                state_d = StRegAck;
                            end else begin
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = ptr_q;
                                wr_data_d   = shift_in;
                                state_d     = StWdataAck;
                            end
                        end
                    end
                end
                StAddrAck, StRegAck, StWdataAck: begin
                    if (ev.scl_fall) begin
                        if (!ack_ph_q) begin
                            sda_oe_d = 1'b1;
                            ack_ph_d = 1'b1;
                        end else begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                            if (state_q == StAddrAck && rw_q) begin
                                shift_d  = bus.rd_data;
                                sda_oe_d = ~bus.rd_data[7];
                                state_d  = StRdata;
                            end else if (state_q == StAddrAck) begin
                                state_d = StReg;
                            end else begin
                                if (state_q == StWdataAck) ptr_d = ptr_q + 8'd1;
                                state_d = StWdata;
                            end
                        end
                    end
                end
                StRdata: begin
                    if (ev.scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == '1) begin
                            sda_oe_d = 1'b0;
                            ack_ph_d = 1'b0;
                            state_d  = StRdataAck;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                StRdataAck: begin
                    // Pointer moves on the ACK rise so rd_addr settles before the load fall.
                    if (ev.scl_rise && !ack_ph_q) begin
                        if (sda_lvl) begin
                            state_d = StIgnore;
                        end else begin
                            ptr_d    = ptr_q + 8'd1;
                            ack_ph_d = 1'b1;
                        end
                    end else if (ev.scl_fall && ack_ph_q) begin
                        shift_d   = bus.rd_data;
                        sda_oe_d  = ~bus.rd_data[7];
                        bit_cnt_d = '0;
                        state_d   = StRdata;
                    end
                end
                StIgnore: sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_addr   = ptr_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Directed bench for i2c_slave_target: drives an I2C master model on the pads.
module tb_i2c_slave_target;
    import i2c_pkg::*;

    localparam int Q = 8;  // clk cycles per SCL quarter period

    logic clk;
    logic rst_n;
    logic scl_drv, sda_drv;
    int   n_chk, n_err;
    logic oe_seen;
    logic [15:0] strobes[$];

    i2c_slave_target_if bus_if ();

    assign bus_if.scl     = scl_drv;
    assign bus_if.sda     = sda_drv & ~bus_if.sda_oe;
    assign bus_if.rd_data = (bus_if.rd_addr == 8'h20) ? 8'hC3 :
                            (bus_if.rd_addr == 8'h21) ? 8'h5E : 8'h00;

    i2c_slave_target #(.SLAVE_ADDR(7'h5A)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record write strobes and any SDA pull-down, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (bus_if.wr_strobe) strobes.push_back({bus_if.wr_addr, bus_if.wr_data});
        if (bus_if.sda_oe) oe_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wq(Q);
        scl_drv = 1'b1; wq(Q);
        sda_drv = 1'b0; wq(Q);
        scl_drv = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wq(Q);
        scl_drv = 1'b1; wq(Q);
        sda_drv = 1'b1; wq(Q);
    endtask

    task automatic wr_bit(input logic b);
        sda_drv = b;    wq(Q);
        scl_drv = 1'b1; wq(2 * Q);
        scl_drv = 1'b0; wq(Q);
    endtask

    task automatic rd_bit(output logic b);
        sda_drv = 1'b1; wq(Q);
        scl_drv = 1'b1; wq(Q);
        b = bus_if.sda; wq(Q);
        scl_drv = 1'b0; wq(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(ack);
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic ack);
        logic bv;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(bv);
            d[i] = bv;
        end
        wr_bit(ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        n_chk   = 0;
        n_err   = 0;
        oe_seen = 1'b0;
        rst_n   = 1'b0;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        wq(4);
        rst_n = 1'b1;
        wq(4);

        // Reset state
        check("rst_sda_oe", 32'(bus_if.sda_oe), 32'd0);
        check("rst_wr_strobe", 32'(bus_if.wr_strobe), 32'd0);
        check("rst_wr_addr", 32'(bus_if.wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus_if.wr_data), 32'd0);
        check("rst_rd_addr", 32'(bus_if.rd_addr), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(StIdle));

        // Single write: 0x5A/W, reg 0x10, data 0xA5
        strobes.delete();
        i2c_start();
        check("t1_busy", 32'(bus_if.busy), 32'd1);
        wr_byte(8'hB4, ack); check("t1_ack_addr", 32'(ack), 32'd0);
        wr_byte(8'h10, ack); check("t1_ack_reg", 32'(ack), 32'd0);
        wr_byte(8'hA5, ack); check("t1_ack_data", 32'(ack), 32'd0);
        i2c_stop();
        check("t1_busy_after_stop", 32'(bus_if.busy), 32'd0);
        check("t1_n_strobes", 32'(strobes.size()), 32'd1);
        if (strobes.size() > 0) check("t1_strobe", 32'(strobes[0]), 32'h10A5);

        // Foreign address 0x3C: never ACKed
        strobes.delete();
        wq(Q);
        oe_seen = 1'b0;
        i2c_start();
        wr_byte(8'h78, ack); check("t2_nack", 32'(ack), 32'd1);
        check("t2_state_ignore", 32'(dut.state_q), 32'(StIgnore));
        wr_byte(8'h55, ack); check("t2_nack_data", 32'(ack), 32'd1);
        check("t2_still_ignore", 32'(dut.state_q), 32'(StIgnore));
        i2c_stop();
        check("t2_oe_never", 32'(oe_seen), 32'd0);
        check("t2_state_idle", 32'(dut.state_q), 32'(StIdle));
        check("t2_n_strobes", 32'(strobes.size()), 32'd0);

        // Pointer write, repeated START, two-byte read
        strobes.delete();
        wq(Q);
        i2c_start();
        wr_byte(8'hB4, ack); check("t3_ack_addr_w", 32'(ack), 32'd0);
        wr_byte(8'h20, ack); check("t3_ack_reg", 32'(ack), 32'd0);
        i2c_start();
        wr_byte(8'hB5, ack); check("t3_ack_addr_r", 32'(ack), 32'd0);
        check("t3_rd_addr0", 32'(bus_if.rd_addr), 32'h20);
        rd_byte(d, 1'b0); check("t3_byte0", 32'(d), 32'hC3);
        check("t3_rd_addr1", 32'(bus_if.rd_addr), 32'h21);
        rd_byte(d, 1'b1); check("t3_byte1", 32'(d), 32'h5E);
        check("t3_sda_released", 32'(bus_if.sda_oe), 32'd0);
        check("t3_state_ignore", 32'(dut.state_q), 32'(StIgnore));
        i2c_stop();
        check("t3_n_strobes", 32'(strobes.size()), 32'd0);

        // Burst write with pointer wrap
        strobes.delete();
        wq(Q);
        i2c_start();
        wr_byte(8'hB4, ack);
        wr_byte(8'hFE, ack);
        wr_byte(8'h11, ack); check("t4_ack0", 32'(ack), 32'd0);
        wr_byte(8'h22, ack); check("t4_ack1", 32'(ack), 32'd0);
        wr_byte(8'h33, ack); check("t4_ack2", 32'(ack), 32'd0);
        i2c_stop();
        check("t4_n_strobes", 32'(strobes.size()), 32'd3);
        if (strobes.size() == 3) begin
            check("t4_strobe0", 32'(strobes[0]), 32'hFE11);
            check("t4_strobe1", 32'(strobes[1]), 32'hFF22);
            check("t4_strobe2", 32'(strobes[2]), 32'h0033);
        end
        check("t4_ptr_after", 32'(bus_if.rd_addr), 32'h01);

        // STOP after four data bits discards the byte
        strobes.delete();
        wq(Q);
        i2c_start();
        wr_byte(8'hB4, ack);
        wr_byte(8'h30, ack);
        for (int i = 0; i < 4; i++) wr_bit(1'b1);
        i2c_stop();
        check("t5_n_strobes", 32'(strobes.size()), 32'd0);
        check("t5_sda_oe", 32'(bus_if.sda_oe), 32'd0);
        check("t5_state_idle", 32'(dut.state_q), 32'(StIdle));

        // Reset while the address ACK is driven
        strobes.delete();
        wq(Q);
        i2c_start();
        for (int i = 7; i >= 0; i--) wr_bit(((8'hB4 >> i) & 8'h01) != 0);
        sda_drv = 1'b1;
        check("t6_ack_driven", 32'(bus_if.sda_oe), 32'd1);
        #3 rst_n = 1'b0;
        #1 check("t6_async_release", 32'(bus_if.sda_oe), 32'd0);
        wq(2);
        scl_drv = 1'b1;
        wq(Q);
        rst_n = 1'b1;
        wq(Q);
        check("t6_state_idle", 32'(dut.state_q), 32'(StIdle));
        i2c_start();
        wr_byte(8'hB4, ack); check("t6_ack_addr", 32'(ack), 32'd0);
        wr_byte(8'h40, ack); check("t6_ack_reg", 32'(ack), 32'd0);
        wr_byte(8'h77, ack); check("t6_ack_data", 32'(ack), 32'd0);
        i2c_stop();
        check("t6_n_strobes", 32'(strobes.size()), 32'd1);
        if (strobes.size() > 0) check("t6_strobe", 32'(strobes[0]), 32'h4077);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_slave_target.md
# i2c_slave_target

Byte-oriented I2C target (slave) that consumes the bus traffic produced by the team's I2C master: 7-bit address, one register-pointer byte, then one or more data bytes. It oversamples SCL/SDA on the system clock, detects START/STOP, ACKs its own address, and exposes register writes and reads to the application as a simple strobe/address/data interface. It sits between the board-level open-drain pads and the device's register bank.

## Interface
- `SLAVE_ADDR`, default 7'h5A: 7-bit address this target answers to.
- `clk`  in  1: system clock; must be at least 8× the SCL frequency.
- `reset`  in  1: asynchronous, active-low reset.
- `scl_in`  in  1: raw SCL pad input (asynchronous to `clk`).
- `sda_in`  in  1: raw SDA pad input (asynchronous to `clk`).
- `sda_oe`  out  1: 1 = pull SDA low; 0 = release. Never drives high.
- `wr_strobe`  out  1: one-`clk` pulse; `wr_addr`/`wr_data` valid.
- `wr_addr`  out  8: register address of the write.
- `wr_data`  out  8: byte written by the master.
- `rd_addr`  out  8: current register pointer; held stable while a read byte is loaded.
- `rd_data`  in  8: application data for `rd_addr`; sampled combinationally when a read byte is loaded.
- `busy`  out  1: 1 from START until STOP.

## Operation
- Input conditioning: `scl_in`/`sda_in` pass through 2-flop synchronisers plus one history flop; edge and START/STOP detection use the synchronised values only.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high. START/STOP are recognised in every state and take priority over bit processing.
- Data bits are sampled on the detected SCL rise; `sda_oe` changes only on the detected SCL fall.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE: on START -> ADDR, bit counter = 0.
- ADDR: shift 8 bits MSB first (7 address bits + R/W). On the 8th rise: if address = `SLAVE_ADDR` -> ADDR_ACK; else -> IGNORE.
- ADDR_ACK: assert `sda_oe` from the next SCL fall to the following SCL fall. Then R/W = 0 -> REG; R/W = 1 -> RDATA (load `rd_data` into the shift register at this fall; drive its MSB).
- REG: shift 8 bits into the pointer; on the 8th rise -> REG_ACK (ACK as above) -> WDATA.
- WDATA: shift 8 bits; on the 8th rise pulse `wr_strobe` with `wr_addr` = pointer, `wr_data` = byte; -> WDATA_ACK (ACK); pointer increments at the end of the ACK; -> WDATA.
- RDATA: drive bit 7..0 on successive SCL falls (`sda_oe` = ~bit). After the 8th bit release SDA -> RDATA_ACK.
- RDATA_ACK: sample SDA on the rise. ACK (0): pointer += 1, load `rd_data`, -> RDATA. NACK (1): -> IGNORE.
- IGNORE: `sda_oe` = 0; wait for START (-> ADDR) or STOP (-> IDLE).
- STOP in any state -> IDLE, `sda_oe` = 0 at once. START in any state (repeated START) -> ADDR, pointer retained.
- Pointer is 8 bits and wraps 8'hFF -> 8'h00. Address 7'h00 (general call) is not ACKed unless it equals `SLAVE_ADDR`.

## Timing
- Reset values: `sda_oe` = 0, `wr_strobe` = 0, `wr_addr` = 0, `wr_data` = 0, `rd_addr` = 0, `busy` = 0, state IDLE, pointer 0. Reset deasserted mid-transfer: target stays in IDLE until the next START.
- Pad-to-detect latency: 3 `clk` from a pad edge to the internal edge flag.
- `sda_oe` changes 1 `clk` after a detected SCL fall, well inside the SCL-low period.
- `wr_strobe` fires 1 `clk` after the 8th detected SCL rise of a write byte, before the ACK is driven.
- `rd_addr` is updated at least 1 `clk` before `rd_data` is sampled; the application must return `rd_data` combinationally or from registers stable in that cycle.
- START/STOP detected in the same cycle as an SCL edge: START/STOP wins; the partial byte is discarded and no `wr_strobe` is generated.

## Structure
- Shared package `i2c_pkg`: state encoding localparams (4-bit), bit-count width, and the START/STOP/edge flag definitions shared with the master.
- Sub-module `i2c_line_sync`: one instance per line (SCL, SDA); 2-flop synchroniser plus rise/fall outputs. The top file holds the FSM, shift register, bit counter and pointer.

## Test plan
- Write 0x5A (W), reg 0x10, data 0xA5, STOP -> three ACKs; one `wr_strobe` with `wr_addr` = 0x10, `wr_data` = 0xA5; `busy` falls after STOP.
- Address 0x3C (W) -> SDA never pulled low (NACK), no `wr_strobe`; FSM in IGNORE until STOP.
- Write reg 0x20, repeated START, 0x5A (R), app returns 0x20 -> 0xC3, master ACK then NACK -> bytes 0xC3 and the 0x21 value read; `rd_addr` 0x20 then 0x21; SDA released after NACK.
- Burst write reg 0xFE, data 0x11, 0x22, 0x33 -> strobes at 0xFE, 0xFF, 0x00 (wrap).
- STOP injected after 4 data bits -> no `wr_strobe`, `sda_oe` = 0, state IDLE.
- `reset` asserted while ACK is being driven -> `sda_oe` = 0 without waiting for `clk`. After release, a new full write transaction completes normally.
